// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller between the UART receiver FSM and host logic.
//
// Gates receiver events with rx_en and pairs a parity-error pulse with the byte that
// follows it. Accepted bytes and their parity flags go into a show-ahead FIFO. The block
// also raises the threshold, idle-timeout and overflow interrupts.
//
// Optional feature macro: UART_RX_CTRL_STATS_EN
//   defined   -> saturating parity/frame error counters are implemented
//   undefined -> counter outputs tied to 0; clr_status clears only overflow
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   rx_en             accept receiver events when 1
//   rx_data/rx_valid  received byte and its 1-cycle valid pulse
//   parity_error      1-cycle parity pulse, pairs with the next byte
//   frame_error       1-cycle bad-stop pulse, byte already discarded by the receiver
//   discard_perr      drop bytes flagged with a parity error instead of storing them
//   flush             empty FIFO, clear pending parity and timeout
//   clr_status        clear overflow and error counters
//   rd_ready          host pop handshake
//   rd_valid/rd_data/rd_perr  FIFO head (show-ahead)
//   fifo_count        occupancy 0..DEPTH
//   overflow          sticky, byte dropped on full FIFO
//   timeout           FIFO non-empty and idle for TIMEOUT_CYC cycles
//   parity_err_cnt/frame_err_cnt  saturating error counters
//   irq               registered interrupt
module uart_rx_ctrl #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CLK_PER_BIT = 5208,
    parameter int unsigned TIMEOUT_CYC = 4 * 5208 * 10,
    parameter int unsigned IRQ_THRESH  = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_en,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    parity_error,
    input  logic                    frame_error,
    input  logic                    discard_perr,
    input  logic                    flush,
    input  logic                    clr_status,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [7:0]              rd_data,
    output logic                    rd_perr,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic                    timeout,
    output logic [CNT_W-1:0]        parity_err_cnt,
    output logic [CNT_W-1:0]        frame_err_cnt,
    output logic                    irq
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned WinCyc = 2 * CLK_PER_BIT;
    localparam int unsigned WinW   = $clog2(WinCyc + 1);
    localparam int unsigned ToW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0]   DepthC  = CW'(DEPTH);
    localparam logic [WinW-1:0] WinLast = WinW'(WinCyc - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {StIdle, StParPend} state_e;

    state_e          state_q, state_d;
    logic [WinW-1:0] win_q, win_d;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            irq_q, irq_d;
    logic            push_req, push_perr, do_push, do_pop, full, not_empty;

    // Pairing FSM: a byte is processed against the current state first, then a
    // parity pulse arms the window for the byte that follows it.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        push_req  = 1'b0;
        push_perr = 1'b0;
        if (!rx_en) begin
            state_d = StIdle;
            win_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_valid) push_req = 1'b1;
                end
                StParPend: begin
                    win_d = win_q + 1'b1;
                    if (rx_valid) begin
                        push_req  = !discard_perr;
                        push_perr = 1'b1;
                        state_d   = StIdle;
                    end else if (frame_error || win_q == WinLast) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (parity_error) begin
                state_d = StParPend;
                win_d   = '0;
            end
        end
        if (flush) begin
            state_d = StIdle;
            win_d   = '0;
        end
    end

    assign not_empty = (count_q != '0);
    assign full      = (count_q == DepthC);
    assign do_pop    = not_empty && rd_ready && !flush;
    assign do_push   = push_req && (!full || do_pop) && !flush;

    always_comb begin
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push_req && full && !do_pop) overflow_d = 1'b1;
        end
        if (clr_status) overflow_d = 1'b0;
    end

    // Idle timer: restarts on any FIFO activity or while empty; holds once expired.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
        if (flush || do_push || do_pop || !not_empty) begin
            to_cnt_d  = '0;
            timeout_d = 1'b0;
        end else if (!timeout_q) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == ToLast) timeout_d = 1'b1;
        end
    end

    // Registered interrupt built from next-state values so it lines up with the flags.
    assign irq_d = rx_en && ((32'(count_d) >= IRQ_THRESH) || timeout_d || overflow_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            win_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= {push_perr, rx_data};
    end

`ifdef UART_RX_CTRL_STATS_EN
    logic [CNT_W-1:0] perr_cnt_q, ferr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_status) begin
            perr_cnt_q <= '0;
            ferr_cnt_q <= '0;
        end else begin
            if (rx_en && parity_error && perr_cnt_q != '1) perr_cnt_q <= perr_cnt_q + 1'b1;
            if (rx_en && frame_error && ferr_cnt_q != '1)  ferr_cnt_q <= ferr_cnt_q + 1'b1;
        end
    end

    assign parity_err_cnt = perr_cnt_q;
    assign frame_err_cnt  = ferr_cnt_q;
`else
    assign parity_err_cnt = '0;
    assign frame_err_cnt  = '0;
`endif

    // Head is masked when empty so stale storage never shows on the bus.
    assign rd_valid   = not_empty;
    assign rd_data    = not_empty ? mem[rd_q][7:0] : 8'h00;
    assign rd_perr    = not_empty ? mem[rd_q][8] : 1'b0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios followed by random traffic,
// checked against a timestamp/queue based reference model and a pop-side scoreboard.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CPB   = 8;
    localparam int unsigned TO    = 20;
    localparam int unsigned TH    = 3;
    localparam int unsigned CNTW  = 4;
    localparam int unsigned WIN   = 2 * CPB;
    localparam int          CMAX  = (1 << CNTW) - 1;
`ifdef UART_RX_CTRL_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, rx_en, rx_valid, parity_error, frame_error;
    logic            discard_perr, flush, clr_status, rd_ready;
    logic [7:0]      rx_data;
    logic            rd_valid, rd_perr, overflow, timeout, irq;
    logic [7:0]      rd_data;
    logic [2:0]      fifo_count;
    logic [CNTW-1:0] parity_err_cnt, frame_err_cnt;

    uart_rx_ctrl #(
        .DEPTH       (DEPTH),
        .CLK_PER_BIT (CPB),
        .TIMEOUT_CYC (TO),
        .IRQ_THRESH  (TH),
        .CNT_W       (CNTW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_en          (rx_en),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_error   (parity_error),
        .frame_error    (frame_error),
        .discard_perr   (discard_perr),
        .flush          (flush),
        .clr_status     (clr_status),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_perr        (rd_perr),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .timeout        (timeout),
        .parity_err_cnt (parity_err_cnt),
        .frame_err_cnt  (frame_err_cnt),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int         t = 0;
    int         m_cnt = 0, m_pc = 0, m_fc = 0, idle_t = 0, pend_t = 0;
    bit         pend = 0, m_ovf = 0, m_to = 0, m_irq = 0, m_rst = 0;
    logic [8:0] sb_q[$];

    // Model: evaluates each clock edge from the inputs the driver holds stable.
    initial begin
        forever begin
            bit pop, req, rperr, push;
            @(posedge clk);
            t++;
            if (rst) begin
                m_cnt = 0; m_pc = 0; m_fc = 0; m_ovf = 0; m_to = 0; m_irq = 0;
                pend = 0; idle_t = t; m_rst = 1;
                sb_q.delete();
            end else begin
                m_rst = 0;
                pop   = (m_cnt > 0) && rd_ready && !flush;
                req   = 0;
                rperr = 0;
                if (rx_en) begin
                    if (rx_valid) begin
                        // Byte pairs with a parity pulse seen at most WIN edges earlier.
                        rperr = pend && (t - pend_t <= WIN);
                        req   = !(rperr && discard_perr);
                        pend  = 0;
                    end else if (frame_error) begin
                        pend = 0;
                    end
                    if (parity_error) begin
                        pend   = 1;
                        pend_t = t;
                        if (m_pc < CMAX) m_pc++;
                    end
                    if (frame_error && m_fc < CMAX) m_fc++;
                end else begin
                    pend = 0;
                end
                if (flush) pend = 0;
                push = req && (m_cnt < DEPTH || pop) && !flush;
                if (req && m_cnt == DEPTH && !pop && !flush) m_ovf = 1;
                if (clr_status) begin
                    m_ovf = 0; m_pc = 0; m_fc = 0;
                end
                if (push || pop || flush || m_cnt == 0) idle_t = t;
                if (flush) begin
                    m_cnt = 0;
                    sb_q.delete();
                end else begin
                    m_cnt = m_cnt + int'(push) - int'(pop);
                    if (push) sb_q.push_back({rperr, rx_data});
                end
                m_to  = (m_cnt > 0) && (t - idle_t >= TO);
                m_irq = rx_en && (m_cnt >= TH || m_to || m_ovf);
            end
        end
    end

    // Status checker, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check("rd_valid", rd_valid, m_cnt != 0);
            check("fifo_count", fifo_count, m_cnt);
            check("overflow", overflow, m_ovf);
            check("timeout", timeout, m_to);
            check("irq", irq, m_irq);
            check("parity_err_cnt", parity_err_cnt, StatsEn ? m_pc : 0);
            check("frame_err_cnt", frame_err_cnt, StatsEn ? m_fc : 0);
            if (m_rst) begin
                check("rd_data_reset", rd_data, 0);
                check("rd_perr_reset", rd_perr, 0);
            end
        end
    end

    // Scoreboard monitor: compares the head whenever the DUT is about to hand over a byte.
    initial begin
        forever begin
            logic [8:0] exp;
            @(negedge clk);
            if (!rst && !flush && rd_valid && rd_ready) begin
                check("pop_has_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("rd_data", rd_data, exp[7:0]);
                    check("rd_perr", rd_perr, exp[8]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        rx_valid     = 1'b0;
        parity_error = 1'b0;
        frame_error  = 1'b0;
        flush        = 1'b0;
        clr_status   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
    endtask

    initial begin
        int ready_pct;
        rst = 1'b1; rx_en = 1'b0; rx_valid = 1'b0; parity_error = 1'b0; frame_error = 1'b0;
        discard_perr = 1'b0; flush = 1'b0; clr_status = 1'b0; rd_ready = 1'b0; rx_data = 8'h00;
        repeat (3) step();
        rst = 1'b0; rx_en = 1'b1;

        // Three bytes held, then drained
        for (int i = 0; i < 3; i++) send(8'(8'h41 + i));
        step();
        rd_ready = 1'b1; repeat (4) step(); rd_ready = 1'b0;

        // Parity pairing, stored then discarded
        parity_error = 1'b1; step();
        repeat (9) step();
        send(8'h5A);
        step(); rd_ready = 1'b1; repeat (2) step(); rd_ready = 1'b0;
        discard_perr = 1'b1;
        parity_error = 1'b1; step();
        repeat (9) step();
        send(8'h5A);
        repeat (2) step();
        discard_perr = 1'b0;

        // Parity followed by frame error, then parity window expiry
        parity_error = 1'b1; step();
        repeat (3) step();
        frame_error = 1'b1; step();
        parity_error = 1'b1; step();
        repeat (WIN + 4) step();
        send(8'h11);
        rd_ready = 1'b1; repeat (2) step(); rd_ready = 1'b0;

        // Overflow, push+pop while full, clear
        for (int i = 0; i < 5; i++) send(8'(8'hA0 + i));
        rx_valid = 1'b1; rx_data = 8'hB0; rd_ready = 1'b1; step();
        rd_ready = 1'b0; step();
        clr_status = 1'b1; step();
        rd_ready = 1'b1; repeat (6) step(); rd_ready = 1'b0;

        // Idle timeout, then flush with a colliding byte
        send(8'hC3);
        repeat (24) step();
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'(8'hD0 + i));
        rx_valid = 1'b1; rx_data = 8'hDF; flush = 1'b1; step();
        step();

        // Counter saturation, then clear
        for (int i = 0; i < 18; i++) begin
            parity_error = 1'b1; frame_error = (i % 2) == 0; step();
        end
        clr_status = 1'b1; step();

        // Disabled receiver events
        rx_en = 1'b0;
        send(8'h77);
        parity_error = 1'b1; step();
        frame_error = 1'b1; step();
        rx_en = 1'b1; step();

        // Reset while a parity byte is pending
        send(8'h12);
        parity_error = 1'b1; step();
        step();
        rst = 1'b1; step();
        rst = 1'b0; step();

        // Random traffic
        ready_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (c % 200 == 0) ready_pct = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 50 : 90);
            if (c % 300 == 0) discard_perr = $urandom_range(1);
            r = $urandom_range(99);
            if (r < 20) begin
                rx_valid = 1'b1; rx_data = 8'($urandom);
            end else if (r < 27) begin
                parity_error = 1'b1;
            end else if (r < 30) begin
                frame_error = 1'b1;
            end
            rd_ready   = $urandom_range(99) < ready_pct;
            flush      = $urandom_range(199) == 0;
            clr_status = $urandom_range(149) == 0;
            rx_en      = $urandom_range(49) != 0;
            step();
        end
        rx_en = 1'b1; rd_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
